// File: rtl/gzip_fifo_to_axis_if.sv
`default_nettype none
// ============================================================================
// Module      : gzip_fifo_to_axis_if
// Description : Bundles the GZIP core output FIFO read port and the AXIS
//               master stream used by gzip_fifo_to_axis.
//               master modport : bridge view (reads FIFO, drives AXIS)
//               slave modport  : environment view (FIFO + AXIS sink)
//               Signals:
//                 fifo_empty    FIFO empty flag
//                 fifo_rden     FIFO read strobe (data one cycle later)
//                 fifo_data     FIFO read data
//                 fifo_last     FIFO last-word flag
//                 m_axis_tdata  AXIS data
//                 m_axis_tvalid AXIS valid
//                 m_axis_tready AXIS ready
//                 m_axis_tlast  AXIS last
// Revision    : 1.0 - initial release
// ============================================================================
interface gzip_fifo_to_axis_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  fifo_empty;
    logic                  fifo_rden;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_last;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;

    modport master (
        input  fifo_empty,
        output fifo_rden,
        input  fifo_data,
        input  fifo_last,
        output m_axis_tdata,
        output m_axis_tvalid,
        input  m_axis_tready,
        output m_axis_tlast
    );

    modport slave (
        output fifo_empty,
        input  fifo_rden,
        output fifo_data,
        output fifo_last,
        input  m_axis_tdata,
        input  m_axis_tvalid,
        output m_axis_tready,
        input  m_axis_tlast
    );
endinterface
`default_nettype wire

// File: rtl/gzip_fifo_to_axis.sv
`default_nettype none
// ============================================================================
// Module      : gzip_fifo_to_axis
// Description : Drains the GZIP core output FIFO (read latency 1, non-FWFT)
//               into an AXIS master through a 2-entry prefetch buffer,
//               sustaining one word per cycle, and keeps per-frame word
//               statistics.
// Ports       : clk                 core clock, posedge
//               rst_n               asynchronous active-low reset
//               bus                 FIFO read port + AXIS master (master modport)
//               o_frame_words       words accepted in the current frame
//               o_last_frame_words  word count of last completed frame
//               o_frame_count       completed frames since reset (wraps)
//               o_frame_done        1-cycle pulse after the tlast handshake
// Revision    : 1.0 - initial release
// ============================================================================
module gzip_fifo_to_axis #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 24
) (
    input  wire logic                 clk,
    input  wire logic                 rst_n,
    gzip_fifo_to_axis_if.master       bus,
    output logic [CNT_WIDTH-1:0]      o_frame_words,
    output logic [CNT_WIDTH-1:0]      o_last_frame_words,
    output logic [15:0]               o_frame_count,
    output logic                      o_frame_done
);

    localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = {CNT_WIDTH{1'b1}};

    // Buffer slots: slot 0 is the head and drives the AXIS outputs directly.
    logic [DATA_WIDTH-1:0] r_d0, r_d1;
    logic                  r_l0, r_l1;
    logic [1:0]            r_entries;
    logic                  r_rd_pending;

    logic [CNT_WIDTH-1:0]  r_frame_words;
    logic [CNT_WIDTH-1:0]  r_last_frame_words;
    logic [15:0]           r_frame_count;
    logic                  r_frame_done;

    logic                  w_pop;
    logic                  w_wr;
    logic [2:0]            w_occ;
    logic [2:0]            w_occ_after;
    logic [CNT_WIDTH-1:0]  w_fw_inc;

    assign w_pop       = bus.m_axis_tvalid & bus.m_axis_tready;
    assign w_wr        = r_rd_pending;
    // Occupancy counts the in-flight read so a slot is reserved before the
    // data arrives; a read is only issued when that slot is guaranteed.
    assign w_occ       = {1'b0, r_entries} + {2'b00, r_rd_pending};
    assign w_occ_after = w_occ - {2'b00, w_pop};

    assign bus.fifo_rden     = rst_n & ~bus.fifo_empty & (w_occ_after < 3'd2);
    assign bus.m_axis_tvalid = (r_entries != 2'd0);
    assign bus.m_axis_tdata  = r_d0;
    assign bus.m_axis_tlast  = r_l0;

    // Saturating increment: a frame longer than the counter range reports all-ones.
    assign w_fw_inc = (r_frame_words == c_CNT_MAX) ? c_CNT_MAX : r_frame_words + 1'b1;

    assign o_frame_words      = r_frame_words;
    assign o_last_frame_words = r_last_frame_words;
    assign o_frame_count      = r_frame_count;
    assign o_frame_done       = r_frame_done;

    // ------------------------------------------------------------------
    // Prefetch buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_d0         <= '0;
            r_d1         <= '0;
            r_l0         <= 1'b0;
            r_l1         <= 1'b0;
            r_entries    <= 2'd0;
            r_rd_pending <= 1'b0;
        end else begin
            r_rd_pending <= bus.fifo_rden;
            case (r_entries)
                2'd0: begin
                    if (w_wr) begin
                        r_d0      <= bus.fifo_data;
                        r_l0      <= bus.fifo_last;
                        r_entries <= 2'd1;
                    end
                end
                2'd1: begin
                    if (w_pop && w_wr) begin
                        r_d0 <= bus.fifo_data;
                        r_l0 <= bus.fifo_last;
                    end else if (w_pop) begin
                        r_entries <= 2'd0;
                    end else if (w_wr) begin
                        r_d1      <= bus.fifo_data;
                        r_l1      <= bus.fifo_last;
                        r_entries <= 2'd2;
                    end
                end
                2'd2: begin
                    // A write while full cannot happen: no read is issued
                    // unless a pop frees the slot in the same cycle.
                    if (w_pop) begin
                        r_d0 <= r_d1;
                        r_l0 <= r_l1;
                        if (w_wr) begin
                            r_d1 <= bus.fifo_data;
                            r_l1 <= bus.fifo_last;
                        end else begin
                            r_entries <= 2'd1;
                        end
                    end
                end
                default: r_entries <= 2'd0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame statistics
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_words      <= '0;
            r_last_frame_words <= '0;
            r_frame_count      <= 16'd0;
            r_frame_done       <= 1'b0;
        end else begin
            r_frame_done <= w_pop & bus.m_axis_tlast;
            if (w_pop) begin
                if (bus.m_axis_tlast) begin
                    r_last_frame_words <= w_fw_inc;
                    r_frame_words      <= '0;
                    r_frame_count      <= r_frame_count + 16'd1;
                end else begin
                    r_frame_words <= w_fw_inc;
                end
            end
        end
    end

endmodule
`default_nettype wire
